pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch-stage controller that decides, every cycle, whether and where the program counter moves.
//  Drives the PC register's write-enable and next-address inputs from run/step control, hazard stalls,
//  branch/jump redirects and HALT detection. Sits between hazard/branch units, debug unit and the PC register.
// PARAMETERS
//  NB       32  address width of PC, targets and outputs
//  PC_STEP   4  sequential increment in bytes
//  NB_CNT   32  width of advance counter (only used with PC_SEQ_CYCLE_COUNT_EN)
// PORTS
//  i_clock          in   1       clock, rising edge
//  i_reset          in   1       synchronous, active-high reset
//  i_start          in   1       leave IDLE and begin execution (pulse)
//  i_step_mode      in   1       1 = single-step, 0 = continuous; sampled only in IDLE with i_start
//  i_step           in   1       step request pulse (STEP state only)
//  i_stall          in   1       hazard stall: hold PC this cycle
//  i_halt_detected  in   1       HALT instruction decoded: stop fetching permanently
//  i_jump           in   1       unconditional jump redirect
//  i_jump_target    in   NB      jump destination
//  i_branch_taken   in   1       taken-branch redirect
//  i_branch_target  in   NB      branch destination
//  i_pc             in   NB      current PC register value
//  o_write_new_pc   out  1       PC write-enable
//  o_new_pc         out  NB      next PC value
//  o_pc_plus4       out  NB      i_pc + PC_STEP (link address)
//  o_state          out  2       FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//  o_halted         out  1       1 while in HALTED
//  o_adv_count      out  NB_CNT  number of PC writes since reset
// BEHAVIOUR
//  - Reset: state=IDLE, step_pending=0, adv_count=0; o_write_new_pc=0 during any cycle with i_reset=1.
//  - o_write_new_pc/o_new_pc combinational from state/inputs: PC updates on the same edge (0-cycle latency).
//  - advance = (state==RUN) | (state==STEP & (i_step|step_pending)).
//  - Per-cycle priority: reset > halt > stall > jump > branch > sequential.
//    o_write_new_pc = advance & ~i_halt_detected & ~i_stall.
//    o_new_pc = i_jump ? i_jump_target : i_branch_taken ? i_branch_target : i_pc+PC_STEP.
//  - Targets word-aligned: o_new_pc[1:0] forced to 2'b00. i_pc+PC_STEP wraps modulo 2^NB.
//  - Stall + redirect same cycle: stall wins, no write; upstream re-presents redirect next cycle.
//  - FSM: IDLE --i_start&~i_step_mode--> RUN; IDLE --i_start&i_step_mode--> STEP.
//    RUN/STEP --i_halt_detected--> HALTED (checked in any cycle, overrides same-cycle advance).
//    HALTED sticky until i_reset; i_start, i_step ignored. No writes in IDLE or HALTED.
//  - STEP: i_step sets step_pending if the advance is blocked by stall; step_pending clears on the
//    cycle o_write_new_pc=1. Extra i_step while pending is dropped (one write per pending step).
//  - i_step/i_stall/redirects in IDLE are ignored; step_pending cleared on leaving STEP.
//  - Reset mid-operation: returns to IDLE next edge, pending step and count discarded.
// CONFIGURATION
//  PC_SEQ_CYCLE_COUNT_EN defined: adv_count increments (wrapping) on each cycle o_write_new_pc=1.
//  Not defined: no counter register; o_adv_count tied to 0.
// TESTING
//  1. Reset, i_start=1,i_step_mode=0, i_pc=0 -> o_state=01, o_write_new_pc=1, o_new_pc=0x4.
//  2. RUN, i_stall=1 with i_jump=1,i_jump_target=0x40 -> o_write_new_pc=0; next cycle stall=0 -> o_new_pc=0x40.
//  3. RUN, i_jump=1 (0x80) and i_branch_taken=1 (0x20) together -> o_new_pc=0x80; target 0x23 -> 0x20.
//  4. STEP, i_step pulse while i_stall=1 for 3 cycles -> no write until stall drops, then exactly one write.
//  5. RUN, i_halt_detected=1 -> o_write_new_pc=0 that cycle, o_state=11; i_start ignored; i_reset -> 00.
//  6. i_pc=0xFFFFFFFC sequential -> o_new_pc=0x0; with PC_SEQ_CYCLE_COUNT_EN, 10 advances -> o_adv_count=10.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the hazard/branch/debug units (master) and pc_sequencer (slave).
// Carries run/step control, stall, halt, redirects, the current PC and the sequencer's PC-update outputs.
interface pc_sequencer_if #(
    parameter int NB     = 32,
    parameter int NB_CNT = 32
);
    logic              i_start;
    logic              i_step_mode;
    logic              i_step;
    logic              i_stall;
    logic              i_halt_detected;
    logic              i_jump;
    logic [NB-1:0]     i_jump_target;
    logic              i_branch_taken;
    logic [NB-1:0]     i_branch_target;
    logic [NB-1:0]     i_pc;
    logic              o_write_new_pc;
    logic [NB-1:0]     o_new_pc;
    logic [NB-1:0]     o_pc_plus4;
    logic [1:0]        o_state;
    logic              o_halted;
    logic [NB_CNT-1:0] o_adv_count;

    modport master (
        output i_start, i_step_mode, i_step, i_stall, i_halt_detected,
               i_jump, i_jump_target, i_branch_taken, i_branch_target, i_pc,
        input  o_write_new_pc, o_new_pc, o_pc_plus4, o_state, o_halted, o_adv_count
    );

    modport slave (
        input  i_start, i_step_mode, i_step, i_stall, i_halt_detected,
               i_jump, i_jump_target, i_branch_taken, i_branch_target, i_pc,
        output o_write_new_pc, o_new_pc, o_pc_plus4, o_state, o_halted, o_adv_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: decides each cycle whether the PC register is written and with what.
// Optional advance counter enabled by defining PC_SEQ_CYCLE_COUNT_EN.
module pc_sequencer #(
    parameter int NB      = 32,
    parameter int PC_STEP = 4,
    parameter int NB_CNT  = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    pc_sequencer_if.slave    io_bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [NB-1:0] STEP_INC = NB'(PC_STEP);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_step_pending;
    logic          w_step_pending_next;
    logic          w_advance;
    logic          w_write;
    logic [NB-1:0] w_pc_plus;
    logic [NB-1:0] w_target;

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_step_pending <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_step_pending <= w_step_pending_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.i_start)
                    w_state_next = io_bus.i_step_mode ? ST_STEP : ST_RUN;
            end
            ST_RUN, ST_STEP: begin
                if (io_bus.i_halt_detected)
                    w_state_next = ST_HALTED;
            end
            default: w_state_next = ST_HALTED;
        endcase

        // A step blocked by a stall is remembered; further requests merge into the one pending.
        w_step_pending_next = 1'b0;
        if (r_state == ST_STEP && w_state_next == ST_STEP)
            w_step_pending_next = (io_bus.i_step | r_step_pending) & ~w_write;
    end

    // Output logic: same-cycle PC update
    always_comb begin
        w_advance = (r_state == ST_RUN) ||
                    ((r_state == ST_STEP) && (io_bus.i_step || r_step_pending));
        w_write   = w_advance & ~io_bus.i_halt_detected & ~io_bus.i_stall & ~i_reset;
        w_pc_plus = io_bus.i_pc + STEP_INC;
        w_target  = io_bus.i_jump         ? io_bus.i_jump_target   :
                    io_bus.i_branch_taken ? io_bus.i_branch_target : w_pc_plus;
    end

    assign io_bus.o_write_new_pc = w_write;
    assign io_bus.o_new_pc       = {w_target[NB-1:2], 2'b00};
    assign io_bus.o_pc_plus4     = w_pc_plus;
    assign io_bus.o_state        = r_state;
    assign io_bus.o_halted       = (r_state == ST_HALTED);

`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [NB_CNT-1:0] r_adv_count;

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_adv_count <= '0;
        else if (w_write)
            r_adv_count <= r_adv_count + 1'b1;
    end

    assign io_bus.o_adv_count = r_adv_count;
`else
    assign io_bus.o_adv_count = {NB_CNT{1'b0}};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven rows push expectations to a scoreboard,
// which is popped and compared one time unit after the inputs settle.
module tb_pc_sequencer;

    logic i_clock = 1'b0;
    logic i_reset;

    always #5 i_clock = ~i_clock;

    pc_sequencer_if #(.NB(32), .NB_CNT(32)) ifc ();

    pc_sequencer #(.NB(32), .PC_STEP(4), .NB_CNT(32)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .io_bus  (ifc)
    );

    typedef struct {
        logic        rst, start, mode, step, stall, halt, jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt, pc;
        logic        we;
        logic [31:0] npc;
        logic [1:0]  st;
    } row_t;

    typedef struct {
        logic        we;
        logic [31:0] npc;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic drv(input row_t r);
        @(negedge i_clock);
        i_reset              = r.rst;
        ifc.i_start          = r.start;
        ifc.i_step_mode      = r.mode;
        ifc.i_step           = r.step;
        ifc.i_stall          = r.stall;
        ifc.i_halt_detected  = r.halt;
        ifc.i_jump           = r.jump;
        ifc.i_jump_target    = r.jt;
        ifc.i_branch_taken   = r.br;
        ifc.i_branch_target  = r.bt;
        ifc.i_pc             = r.pc;
        sb.push_back('{r.we, r.npc, r.st});
        #1;
    endtask

    function automatic row_t mk(input logic rst, start, mode, step, stall, halt, jump,
                                input logic [31:0] jt, input logic br, input logic [31:0] bt,
                                input logic [31:0] pc, input logic we, input logic [31:0] npc,
                                input logic [1:0] st);
        row_t r;
        r = '{rst, start, mode, step, stall, halt, jump, jt, br, bt, pc, we, npc, st};
        return r;
    endfunction

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1,1,0,1,0,0,0, 0,0,0, 32'h0, 0, 32'h4, 2'b00));
        rows.push_back(mk(1,1,0,0,0,0,1, 32'h40,0,0, 32'h0, 0, 32'h40, 2'b00));
        foreach (rows[i]) begin
            drv(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({ifc.o_write_new_pc, ifc.o_new_pc, ifc.o_state, ifc.o_halted, ifc.o_adv_count} !==
                {e.we, e.npc, e.st, (e.st == 2'b11), 32'h0}) begin
                errors++;
                $display("FAIL reset[%0d] got we=%b pc=%h st=%b hlt=%b cnt=%0d want we=%b pc=%h st=%b cnt=0",
                         i, ifc.o_write_new_pc, ifc.o_new_pc, ifc.o_state, ifc.o_halted, ifc.o_adv_count,
                         e.we, e.npc, e.st);
            end
        end
    endtask

    // Covers start into RUN, stall vs. redirect, jump/branch priority, alignment and wrap.
    task automatic test_run();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0,1,0,0,0,0,0, 0,0,0, 32'h0, 0, 32'h4, 2'b00));
        rows.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 32'h0, 1, 32'h4, 2'b01));
        rows.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 32'h8, 1, 32'hC, 2'b01));
        rows.push_back(mk(0,0,0,0,1,0,1, 32'h40,0,0, 32'hC, 0, 32'h40, 2'b01));
        rows.push_back(mk(0,0,0,0,0,0,1, 32'h40,0,0, 32'hC, 1, 32'h40, 2'b01));
        rows.push_back(mk(0,0,0,0,0,0,1, 32'h80,1,32'h20, 32'h40, 1, 32'h80, 2'b01));
        rows.push_back(mk(0,0,0,0,0,0,0, 0,1,32'h23, 32'h80, 1, 32'h20, 2'b01));
        rows.push_back(mk(0,0,0,0,0,0,1, 32'h47,0,0, 32'h20, 1, 32'h44, 2'b01));
        rows.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 32'hFFFF_FFFC, 1, 32'h0, 2'b01));
        rows.push_back(mk(0,0,0,0,1,0,0, 0,1,32'h10, 32'h100, 0, 32'h10, 2'b01));
        foreach (rows[i]) begin
            drv(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({ifc.o_write_new_pc, ifc.o_new_pc, ifc.o_state, ifc.o_halted} !==
                {e.we, e.npc, e.st, (e.st == 2'b11)}) begin
                errors++;
                $display("FAIL run[%0d] got we=%b pc=%h st=%b want we=%b pc=%h st=%b",
                         i, ifc.o_write_new_pc, ifc.o_new_pc, ifc.o_state, e.we, e.npc, e.st);
            end
        end
        checks++;
        if (ifc.o_pc_plus4 !== 32'h104) begin
            errors++;
            $display("FAIL pc_plus4 got %h want 00000104", ifc.o_pc_plus4);
        end
    endtask

    task automatic test_halt();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0,0,0,0,0,1,0, 0,0,0, 32'h200, 0, 32'h204, 2'b01));
        rows.push_back(mk(0,1,0,1,0,0,0, 0,0,0, 32'h200, 0, 32'h204, 2'b11));
        rows.push_back(mk(0,1,1,1,0,0,1, 32'h40,0,0, 32'h200, 0, 32'h40, 2'b11));
        rows.push_back(mk(1,0,0,0,0,0,0, 0,0,0, 32'h200, 0, 32'h204, 2'b11));
        rows.push_back(mk(0,0,0,1,0,0,0, 0,0,0, 32'h200, 0, 32'h204, 2'b00));
        rows.push_back(mk(0,0,0,1,1,1,1, 32'h40,1,32'h50, 32'h200, 0, 32'h40, 2'b00));
        foreach (rows[i]) begin
            drv(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({ifc.o_write_new_pc, ifc.o_new_pc, ifc.o_state, ifc.o_halted} !==
                {e.we, e.npc, e.st, (e.st == 2'b11)}) begin
                errors++;
                $display("FAIL halt[%0d] got we=%b pc=%h st=%b hlt=%b want we=%b pc=%h st=%b",
                         i, ifc.o_write_new_pc, ifc.o_new_pc, ifc.o_state, ifc.o_halted,
                         e.we, e.npc, e.st);
            end
        end
    endtask

    task automatic test_step();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0,1,1,0,0,0,0, 0,0,0, 32'h300, 0, 32'h304, 2'b00));
        rows.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 32'h300, 0, 32'h304, 2'b10));
        rows.push_back(mk(0,0,0,1,1,0,0, 0,0,0, 32'h300, 0, 32'h304, 2'b10));
        rows.push_back(mk(0,0,0,0,1,0,0, 0,0,0, 32'h300, 0, 32'h304, 2'b10));
        rows.push_back(mk(0,0,0,0,1,0,0, 0,0,0, 32'h300, 0, 32'h304, 2'b10));
        rows.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 32'h300, 1, 32'h304, 2'b10));
        rows.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 32'h304, 0, 32'h308, 2'b10));
        rows.push_back(mk(0,0,0,1,0,0,0, 0,0,0, 32'h304, 1, 32'h308, 2'b10));
        rows.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 32'h308, 0, 32'h30C, 2'b10));
        rows.push_back(mk(0,0,0,1,1,0,0, 0,0,0, 32'h308, 0, 32'h30C, 2'b10));
        rows.push_back(mk(0,0,0,1,1,0,0, 0,0,0, 32'h308, 0, 32'h30C, 2'b10));
        rows.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 32'h308, 1, 32'h30C, 2'b10));
        rows.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 32'h30C, 0, 32'h310, 2'b10));
        rows.push_back(mk(0,0,0,1,0,0,0, 0,1,32'h123, 32'h30C, 1, 32'h120, 2'b10));
        rows.push_back(mk(0,0,0,1,0,1,0, 0,0,0, 32'h120, 0, 32'h124, 2'b10));
        rows.push_back(mk(0,0,0,1,0,0,0, 0,0,0, 32'h120, 0, 32'h124, 2'b11));
        foreach (rows[i]) begin
            drv(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({ifc.o_write_new_pc, ifc.o_new_pc, ifc.o_state} !== {e.we, e.npc, e.st}) begin
                errors++;
                $display("FAIL step[%0d] got we=%b pc=%h st=%b want we=%b pc=%h st=%b",
                         i, ifc.o_write_new_pc, ifc.o_new_pc, ifc.o_state, e.we, e.npc, e.st);
            end
        end
    endtask

    task automatic test_back_to_back_count();
        row_t rows[$];
        exp_t e;
        logic [31:0] want_cnt;
        int          n_writes = 0;
        rows.push_back(mk(1,0,0,0,0,0,0, 0,0,0, 32'h0, 0, 32'h4, 2'b11));
        rows.push_back(mk(0,1,0,0,0,0,0, 0,0,0, 32'h0, 0, 32'h4, 2'b00));
        for (int k = 0; k < 10; k++)
            rows.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 32'(k*4), 1, 32'(k*4+4), 2'b01));
        rows.push_back(mk(0,0,0,0,1,0,0, 0,0,0, 32'h28, 0, 32'h2C, 2'b01));
        foreach (rows[i]) begin
            drv(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({ifc.o_write_new_pc, ifc.o_new_pc, ifc.o_state} !== {e.we, e.npc, e.st}) begin
                errors++;
                $display("FAIL b2b[%0d] got we=%b pc=%h st=%b want we=%b pc=%h st=%b",
                         i, ifc.o_write_new_pc, ifc.o_new_pc, ifc.o_state, e.we, e.npc, e.st);
            end
            if (e.we === 1'b1) n_writes++;
        end
`ifdef PC_SEQ_CYCLE_COUNT_EN
        want_cnt = 32'(n_writes);
`else
        want_cnt = 32'h0;
`endif
        checks++;
        if (ifc.o_adv_count !== want_cnt) begin
            errors++;
            $display("FAIL adv_count got %0d want %0d", ifc.o_adv_count, want_cnt);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        drv(mk(1,0,0,0,0,0,0, 0,0,0, 32'h0, 0, 32'h4, 2'b00));
        void'(sb.pop_front());
        repeat (2) @(posedge i_clock);
        test_reset();
        test_run();
        test_halt();
        test_step();
        test_back_to_back_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
